// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port word memory behind a valid/ready request/response handshake.
//   Each accepted request produces exactly one response LATENCY cycles later;
//   misaligned or out-of-range addresses complete with rsp_err=1.
// Parameters
//   DEPTH_WORDS : number of 32-bit storage words (power of two, >= 4)
//   LATENCY     : cycles from request acceptance to rsp_valid (>= 1)
// Ports
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid / req_ready       : request handshake (ready only when idle)
//   req_we, req_addr, req_wdata : write enable, byte address, write data
//   req_be                      : byte enables for writes
//   rsp_valid / rsp_ready       : response handshake
//   rsp_rdata, rsp_err          : read data (0 for writes/errors), error flag
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept;
  logic          enter_resp;

  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;

  logic          src_we;
  logic [31:0]   src_addr;
  logic [31:0]   src_wdata;
  logic [3:0]    src_be;
  logic          src_err;
  logic [AW-1:0] src_idx;

  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 the RESP entry edge is the accepting edge itself, so the
  // request fields must come straight from the inputs rather than the latch.
  always_comb begin
    if (state == IDLE) begin
      src_we    = req_we;
      src_addr  = req_addr;
      src_wdata = req_wdata;
      src_be    = req_be;
    end else begin
      src_we    = lat_we;
      src_addr  = lat_addr;
      src_wdata = lat_wdata;
      src_be    = lat_be;
    end
    // Full 30-bit word index compared so high addresses never alias.
    src_err = (src_addr[1:0] != 2'b00) ||
              ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS));
    src_idx = src_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= src_err;
      rsp_rdata <= (src_err || src_we) ? '0 : mem[src_idx];
    end
  end

  // Storage is deliberately not reset; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && !src_err && src_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (src_be[b]) begin
          mem[src_idx][8*b +: 8] <= src_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int D0 = 64;
  localparam int L0 = 2;
  localparam int D1 = 16;
  localparam int L1 = 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        rv = 1'b0, rwe = 1'b0, rrdy = 1'b1;
  logic [31:0] raddr = '0, rwd = '0;
  logic [3:0]  rbe = '0;
  logic        rdy0, vld0, er0;
  logic [31:0] rd0;

  logic        rv1 = 1'b0, rwe1 = 1'b0, rrdy1 = 1'b1;
  logic [31:0] ra1 = '0, rwd1 = '0;
  logic [3:0]  rbe1 = '0;
  logic        rdy1, vld1, er1;
  logic [31:0] rd1;

  int n_cmp = 0;
  int n_bad = 0;
  int bp_mode = 0;
  int hold0 = 0;
  bit l1_on = 1'b0;
  int l1_n = 0;
  int l1_acc = 0;

  logic [31:0] ref0 [D0];
  logic [31:0] ref1 [D1];
  exp_t exp0[$];
  exp_t exp1[$];
  int   acc0[$];
  int   acc1[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(D0), .LATENCY(L0)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(rv), .req_ready(rdy0), .req_we(rwe), .req_addr(raddr),
    .req_wdata(rwd), .req_be(rbe),
    .rsp_valid(vld0), .rsp_ready(rrdy), .rsp_rdata(rd0), .rsp_err(er0)
  );

  data_mem_responder #(.DEPTH_WORDS(D1), .LATENCY(L1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_ready(rdy1), .req_we(rwe1), .req_addr(ra1),
    .req_wdata(rwd1), .req_be(rbe1),
    .rsp_valid(vld1), .rsp_ready(rrdy1), .rsp_rdata(rd1), .rsp_err(er1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: word memory with byte-enable writes; errors touch nothing.
  function automatic exp_t model(input int which, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be);
    exp_t r;
    int unsigned depth = (which != 0) ? D1 : D0;
    int unsigned idx = a / 4;
    logic [31:0] w;
    r.rd  = '0;
    r.err = ((a % 4) != 0) || (idx >= depth);
    if (!r.err) begin
      w = (which != 0) ? ref1[idx] : ref0[idx];
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        if (which != 0) ref1[idx] = w;
        else ref0[idx] = w;
      end else begin
        r.rd = w;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_addr(input int depth);
    int r = $urandom_range(0, 9);
    logic [31:0] a;
    if (r < 7)      a = 32'($urandom_range(0, depth - 1)) * 4;
    else if (r < 8) a = 32'($urandom_range(0, depth - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (r < 9) a = 32'($urandom_range(depth, depth + 3)) * 4;
    else            a = $urandom | 32'h8000_0000;
    return a;
  endfunction

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit track);
    int g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!rdy0 && g < 200);
    if (!rdy0) begin
      fail_now("req_ready_timeout");
      return;
    end
    rv = 1'b1; rwe = we; raddr = a; rwd = wd; rbe = be;
    if (track) exp0.push_back(model(0, we, a, wd, be));
    @(posedge clk); #1;
    rv = 1'b0;
    rwe = 1'($urandom); raddr = $urandom; rwd = $urandom; rbe = 4'($urandom);
  endtask

  task automatic drain0();
    int g = 0;
    while (exp0.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (exp0.size() != 0) fail_now("drain_timeout");
  endtask

  // Response backpressure driver
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0: rrdy = 1'b1;
      1: rrdy = ($urandom_range(0, 2) != 0);
      default: rrdy = 1'b0;
    endcase
  end

  // Monitor for the LATENCY=2 instance
  int  ncyc0 = 0;
  bit  first0 = 1'b1;
  bit  rst_prev0 = 1'b0;
  bit  prev_hs0 = 1'b0;
  always @(negedge clk) begin
    ncyc0++;
    if (reset) begin
      acc0.delete();
      first0 = 1'b1;
      prev_hs0 = 1'b0;
      if (rst_prev0) begin
        chk("rst_req_ready", 32'(rdy0), 32'd1);
        chk("rst_rsp_valid", 32'(vld0), 32'd0);
        chk("rst_rdata", rd0, 32'd0);
        chk("rst_err", 32'(er0), 32'd0);
      end
      rst_prev0 = 1'b1;
    end else begin
      rst_prev0 = 1'b0;
      if (prev_hs0) chk("ready_after_hs", 32'(rdy0), 32'd1);
      prev_hs0 = 1'b0;
      if (rv && rdy0) acc0.push_back(ncyc0);
      if (vld0) begin
        if (exp0.size() == 0) begin
          fail_now("spurious_rsp_valid");
        end else begin
          chk("rdata", rd0, exp0[0].rd);
          chk("err", 32'(er0), 32'(exp0[0].err));
          chk("ready_low_in_resp", 32'(rdy0), 32'd0);
          if (first0) begin
            if (acc0.size() == 0) fail_now("no_accept_record");
            else chk("latency", 32'(ncyc0 - acc0[0]), 32'(L0));
            first0 = 1'b0;
          end
          if (!rrdy) hold0++;
          if (rrdy) begin
            void'(exp0.pop_front());
            if (acc0.size() != 0) void'(acc0.pop_front());
            first0 = 1'b1;
            prev_hs0 = 1'b1;
          end
        end
      end
    end
  end

  // Driver for the LATENCY=1 instance: valid held high, fresh fields only
  // when idle, garbage while busy.
  always @(posedge clk) begin
    #1;
    rv1 = l1_on;
    if (l1_on && rdy1) begin
      if (l1_n < D1) begin
        rwe1 = 1'b1; ra1 = 32'(l1_n) * 4; rwd1 = $urandom; rbe1 = 4'hF;
      end else begin
        rwe1 = 1'($urandom); ra1 = gen_addr(D1); rwd1 = $urandom; rbe1 = 4'($urandom);
      end
      l1_n++;
    end else begin
      rwe1 = 1'($urandom); ra1 = $urandom; rwd1 = $urandom; rbe1 = 4'($urandom);
    end
  end

  int ncyc1 = 0;
  int last1 = -1;
  always @(negedge clk) begin
    ncyc1++;
    if (!reset) begin
      if (vld1) begin
        if (exp1.size() == 0) begin
          fail_now("l1_spurious_rsp_valid");
        end else begin
          chk("l1_rdata", rd1, exp1[0].rd);
          chk("l1_err", 32'(er1), 32'(exp1[0].err));
          chk("l1_latency", 32'(ncyc1 - acc1[0]), 32'(L1));
          void'(exp1.pop_front());
          void'(acc1.pop_front());
        end
      end
      if (rv1 && rdy1) begin
        exp1.push_back(model(1, rwe1, ra1, rwd1, rbe1));
        acc1.push_back(ncyc1);
        if (last1 >= 0) chk("l1_accept_spacing", 32'(ncyc1 - last1), 32'(L1 + 1));
        last1 = ncyc1;
        l1_acc++;
      end
    end
  end

  initial begin
    #200000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < D0; i++) issue(1'b1, 32'(i) * 4, $urandom, 4'hF, 1'b1);

    // Basic write/read
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    // Partial write
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b1);
    // Zero byte enables
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    // Errors: misaligned and out of range, reads and writes, no aliasing
    issue(1'b0, 32'h13, 32'h0, 4'hF, 1'b1);
    issue(1'b0, 32'(4 * D0), 32'h0, 4'hF, 1'b1);
    issue(1'b1, 32'h13, 32'h55555555, 4'hF, 1'b1);
    issue(1'b1, 32'(4 * D0), 32'h66666666, 4'hF, 1'b1);
    issue(1'b1, 32'(4 * D0) + 32'h10, 32'h77777777, 4'hF, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    drain0();

    // Backpressure: response held for at least 5 cycles
    bp_mode = 2;
    hold0 = 0;
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    repeat (6) @(posedge clk);
    bp_mode = 0;
    drain0();
    chk("bp_hold_cycles", 32'(hold0 >= 5), 32'd1);

    // Reset while the write is in WAIT drops it
    issue(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1);
    drain0();
    issue(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    issue(1'b0, 32'h40, 32'h0, 4'hF, 1'b1);
    drain0();

    // Randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 150; i++)
      issue(1'($urandom), gen_addr(D0), $urandom, 4'($urandom), 1'b1);
    drain0();
    bp_mode = 0;

    // LATENCY=1 back-to-back traffic
    l1_on = 1'b1;
    repeat (90) @(posedge clk);
    #3 l1_on = 1'b0;
    repeat (6) @(posedge clk);
    chk("l1_queue_empty", 32'(exp1.size()), 32'd0);
    chk("l1_accept_count_ok", 32'(l1_acc >= 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
